// File: rtl/cam_pkg.sv
// Shared definitions for the camera button sequencer: command codes,
// FSM state encoding and default mode count.
package cam_pkg;

  localparam int unsigned DEF_NUM_MODES = 5;
  localparam int unsigned CMD_BITS      = 2;

  typedef logic [CMD_BITS-1:0] cmd_code_t;

  localparam cmd_code_t CMD_CAPTURE   = 2'd0;
  localparam cmd_code_t CMD_MODE_NEXT = 2'd1;
  localparam cmd_code_t CMD_MODE_PREV = 2'd2;
  localparam cmd_code_t CMD_MODE_CLR  = 2'd3;

  localparam int unsigned STATE_BITS = 2;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_VS  = 2'd1;
  localparam logic [1:0] REQ      = 2'd2;
  localparam logic [1:0] WAIT_ACK = 2'd3;

endpackage

// File: rtl/cam_button_ctrl_prio_pick.sv
// Lowest-set-bit priority encoder: returns the winning index and a
// one-hot mask used to clear the granted request.
module prio_pick #(
  parameter int unsigned N        = 4,
  parameter int unsigned IDX_BITS = 2
) (
  input  logic [N-1:0]        req,
  output logic [IDX_BITS-1:0] idx_c,
  output logic [N-1:0]        mask_c
);

  // Scan high to low so the lowest set bit is the last to write.
  always_comb begin
    idx_c  = '0;
    mask_c = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx_c     = IDX_BITS'(i);
        mask_c    = '0;
        mask_c[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cam_button_ctrl.sv
// Button command sequencer: queues button pulses, issues one command per
// frame on vsync rising edge, handshakes it and owns freeze / filter state.
module cam_button_ctrl
  import cam_pkg::*;
#(
  parameter int unsigned NUM_BTN     = 4,
  parameter int unsigned NUM_MODES   = DEF_NUM_MODES,
  parameter int unsigned MODE_BITS   = 3,
  parameter int unsigned ACK_TIMEOUT = 1024,
  parameter int unsigned TO_BITS     = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_BTN-1:0]   btn_pulse,
  input  logic                 vsync,
  output logic                 cmd_valid,
  output logic [1:0]           cmd_code,
  input  logic                 cmd_ack,
  output logic                 freeze,
  output logic [MODE_BITS-1:0] filter_sel,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int unsigned IDX_BITS = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;

  logic [STATE_BITS-1:0] state, state_next;
  logic [NUM_BTN-1:0]    pending, pending_next, grant_clr;
  logic [IDX_BITS-1:0]   sel, sel_next, pick_idx;
  logic [NUM_BTN-1:0]    pick_mask;
  logic [TO_BITS-1:0]    cnt, cnt_next;
  logic                  vsync_d, vs_rise;
  logic                  cmd_valid_next, freeze_next, timeout_err_next, busy_next;
  logic [1:0]            cmd_code_next;
  logic [MODE_BITS-1:0]  filter_sel_next;
  logic                  sel_is_cmd;

  prio_pick #(.N(NUM_BTN), .IDX_BITS(IDX_BITS)) u_pick (
    .req    (pending),
    .idx_c  (pick_idx),
    .mask_c (pick_mask)
  );

  // Button indices beyond the four defined commands are granted but do nothing.
  if (NUM_BTN > 4) begin : g_wide
    assign sel_is_cmd = (sel[IDX_BITS-1:2] == '0);
  end else begin : g_narrow
    assign sel_is_cmd = 1'b1;
  end

  assign vs_rise = vsync & ~vsync_d;

  always_comb begin
    state_next       = state;
    sel_next         = sel;
    cnt_next         = cnt;
    grant_clr        = '0;
    cmd_valid_next   = cmd_valid;
    cmd_code_next    = cmd_code;
    freeze_next      = freeze;
    filter_sel_next  = filter_sel;
    timeout_err_next = timeout_err;

    case (state)
      IDLE: begin
        if (|pending) begin
          sel_next   = pick_idx;
          grant_clr  = pick_mask;
          state_next = WAIT_VS;
        end
      end
      WAIT_VS: begin
        if (vs_rise) state_next = REQ;
      end
      REQ: begin
        cmd_valid_next = 1'b1;
        cmd_code_next  = 2'(sel);
        cnt_next       = '0;
        state_next     = WAIT_ACK;
      end
      WAIT_ACK: begin
        cnt_next = cnt + TO_BITS'(1);
        // Ack takes precedence over a coincident timeout.
        if (cmd_ack) begin
          cmd_valid_next = 1'b0;
          state_next     = IDLE;
          if (sel_is_cmd) begin
            case (cmd_code)
              CMD_CAPTURE:   freeze_next = ~freeze;
              CMD_MODE_NEXT: filter_sel_next = (filter_sel == MODE_BITS'(NUM_MODES - 1)) ?
                                               '0 : filter_sel + MODE_BITS'(1);
              CMD_MODE_PREV: filter_sel_next = (filter_sel == '0) ?
                                               MODE_BITS'(NUM_MODES - 1) : filter_sel - MODE_BITS'(1);
              default: begin
                filter_sel_next = '0;
                freeze_next     = 1'b0;
              end
            endcase
          end
        end else if (cnt == TO_BITS'(ACK_TIMEOUT - 1)) begin
          cmd_valid_next   = 1'b0;
          timeout_err_next = 1'b1;
          state_next       = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // A new pulse on a bit being granted this cycle stays pending.
    pending_next = (pending & ~grant_clr) | btn_pulse;
    busy_next    = (state_next != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pending     <= '0;
      sel         <= '0;
      cnt         <= '0;
      vsync_d     <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_code    <= '0;
      freeze      <= 1'b0;
      filter_sel  <= '0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      pending     <= pending_next;
      sel         <= sel_next;
      cnt         <= cnt_next;
      vsync_d     <= vsync;
      cmd_valid   <= cmd_valid_next;
      cmd_code    <= cmd_code_next;
      freeze      <= freeze_next;
      filter_sel  <= filter_sel_next;
      timeout_err <= timeout_err_next;
      busy        <= busy_next;
    end
  end

endmodule

// File: tb/tb_cam_button_ctrl.sv
// Directed bench for cam_button_ctrl: a table of single-button commands plus
// hand-written sequences for timing, priority, timeout and reset corners.
module tb_cam_button_ctrl;
  import cam_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_pulse;
  logic       vsync;
  logic       cmd_ack;
  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic       freeze;
  logic [2:0] filter_sel;
  logic       busy;
  logic       timeout_err;

  int unsigned total  = 0;
  int unsigned passed = 0;

  typedef struct {
    logic [3:0] btn;
    logic [1:0] code;
    logic       frz;
    logic [2:0] flt;
  } vec_t;

  vec_t tbl [11];

  cam_button_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .btn_pulse   (btn_pulse),
    .vsync       (vsync),
    .cmd_valid   (cmd_valid),
    .cmd_code    (cmd_code),
    .cmd_ack     (cmd_ack),
    .freeze      (freeze),
    .filter_sel  (filter_sel),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; btn_pulse = '0; vsync = 1'b0; cmd_ack = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic pulse(input logic [3:0] b);
    btn_pulse = b;
    tick();
    btn_pulse = '0;
  endtask

  task automatic vs_pulse();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!cmd_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid_seen"}, 32'(cmd_valid), 32'd1);
  endtask

  task automatic watch_frames(input int n, output logic seen);
    seen = 1'b0;
    repeat (n) begin
      vsync = 1'b1;
      tick();
      seen |= cmd_valid;
      vsync = 1'b0;
      repeat (4) begin
        tick();
        seen |= cmd_valid;
      end
    end
  endtask

  task automatic do_cmd(input logic [3:0] b, input logic [1:0] code, input string tag);
    pulse(b);
    tick();
    tick();
    vs_pulse();
    wait_valid(tag);
    chk({tag, "_code"}, 32'(cmd_code), 32'(code));
    cmd_ack = 1'b1;
    tick();
    cmd_ack = 1'b0;
    chk({tag, "_valid_drop"}, 32'(cmd_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic seen;
    int   n;

    tbl[0]  = '{4'b0010, CMD_MODE_NEXT, 1'b0, 3'd1};
    tbl[1]  = '{4'b0010, CMD_MODE_NEXT, 1'b0, 3'd2};
    tbl[2]  = '{4'b0010, CMD_MODE_NEXT, 1'b0, 3'd3};
    tbl[3]  = '{4'b0010, CMD_MODE_NEXT, 1'b0, 3'd4};
    tbl[4]  = '{4'b0010, CMD_MODE_NEXT, 1'b0, 3'd0};
    tbl[5]  = '{4'b0100, CMD_MODE_PREV, 1'b0, 3'd4};
    tbl[6]  = '{4'b0100, CMD_MODE_PREV, 1'b0, 3'd3};
    tbl[7]  = '{4'b0001, CMD_CAPTURE,   1'b1, 3'd3};
    tbl[8]  = '{4'b0010, CMD_MODE_NEXT, 1'b1, 3'd4};
    tbl[9]  = '{4'b1000, CMD_MODE_CLR,  1'b0, 3'd0};
    tbl[10] = '{4'b0100, CMD_MODE_PREV, 1'b0, 3'd4};

    // Reset values, then idle frames with a stray ack.
    do_reset();
    chk("rst_valid", 32'(cmd_valid), 32'd0);
    chk("rst_code", 32'(cmd_code), 32'd0);
    chk("rst_freeze", 32'(freeze), 32'd0);
    chk("rst_filter", 32'(filter_sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    cmd_ack = 1'b1;
    watch_frames(5, seen);
    cmd_ack = 1'b0;
    chk("idle_no_valid", 32'(seen), 32'd0);
    chk("idle_freeze", 32'(freeze), 32'd0);
    chk("idle_filter", 32'(filter_sel), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Capture with exact frame-edge and ack timing.
    do_reset();
    pulse(4'b0001);
    chk("t2_busy_pending", 32'(busy), 32'd0);
    tick();
    chk("t2_busy_wait", 32'(busy), 32'd1);
    repeat (19) tick();
    chk("t2_no_valid_before_vs", 32'(cmd_valid), 32'd0);
    vsync = 1'b1;
    tick();
    chk("t2_valid_at_req", 32'(cmd_valid), 32'd0);
    tick();
    vsync = 1'b0;
    chk("t2_valid_rise", 32'(cmd_valid), 32'd1);
    chk("t2_code", 32'(cmd_code), 32'(CMD_CAPTURE));
    repeat (3) begin
      tick();
      chk("t2_valid_held", 32'(cmd_valid), 32'd1);
    end
    cmd_ack = 1'b1;
    tick();
    cmd_ack = 1'b0;
    chk("t2_freeze", 32'(freeze), 32'd1);
    chk("t2_valid_drop", 32'(cmd_valid), 32'd0);
    chk("t2_busy_done", 32'(busy), 32'd0);

    // Two buttons in one cycle: lowest index first, one per frame.
    do_reset();
    pulse(4'b0011);
    tick();
    tick();
    vs_pulse();
    wait_valid("t3a");
    chk("t3a_code", 32'(cmd_code), 32'(CMD_CAPTURE));
    cmd_ack = 1'b1;
    tick();
    cmd_ack = 1'b0;
    tick();
    chk("t3_busy_second", 32'(busy), 32'd1);
    repeat (3) tick();
    chk("t3_no_valid_between", 32'(cmd_valid), 32'd0);
    vs_pulse();
    wait_valid("t3b");
    chk("t3b_code", 32'(cmd_code), 32'(CMD_MODE_NEXT));
    cmd_ack = 1'b1;
    tick();
    cmd_ack = 1'b0;
    chk("t3_freeze", 32'(freeze), 32'd1);
    chk("t3_filter", 32'(filter_sel), 32'd1);

    // Mode wrap, reverse wrap, capture, mode change while frozen, clear.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      do_cmd(tbl[i].btn, tbl[i].code, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_freeze", i), 32'(freeze), 32'(tbl[i].frz));
      chk($sformatf("tbl%0d_filter", i), 32'(filter_sel), 32'(tbl[i].flt));
    end

    // Ack timeout: valid held for the full window, command not applied.
    do_reset();
    pulse(4'b0010);
    tick();
    tick();
    vs_pulse();
    wait_valid("t5");
    n = 0;
    while (cmd_valid && n < 2000) begin
      n++;
      tick();
    end
    chk("t5_valid_cycles", 32'(n), 32'd1024);
    chk("t5_timeout_err", 32'(timeout_err), 32'd1);
    chk("t5_filter_kept", 32'(filter_sel), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    do_cmd(4'b0010, CMD_MODE_NEXT, "t5_next");
    chk("t5_next_filter", 32'(filter_sel), 32'd1);
    chk("t5_err_sticky", 32'(timeout_err), 32'd1);

    // Asynchronous reset mid-handshake with a second request pending.
    do_reset();
    do_cmd(4'b0001, CMD_CAPTURE, "t6cap");
    chk("t6_frozen", 32'(freeze), 32'd1);
    pulse(4'b0010);
    tick();
    tick();
    pulse(4'b0100);
    vs_pulse();
    wait_valid("t6");
    chk("t6_code", 32'(cmd_code), 32'(CMD_MODE_NEXT));
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(cmd_valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_freeze", 32'(freeze), 32'd0);
    chk("t6_rst_code", 32'(cmd_code), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    watch_frames(3, seen);
    chk("t6_no_cmd_after", 32'(seen), 32'd0);
    chk("t6_busy_after", 32'(busy), 32'd0);
    chk("t6_filter_after", 32'(filter_sel), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
